// File: rtl/rr_arbiter_pkg.sv
// Purpose: shared constants, FSM state type and helpers for the round-robin arbiter.
// Ports: none (package).
package rr_arbiter_pkg;

  localparam bit ENABLE  = 1'b1;
  localparam bit DISABLE = 1'b0;
  localparam bit HIGH    = 1'b1;
  localparam bit LOW     = 1'b0;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_selector.sv
// Purpose: fixed-priority pick of one entry out of a request vector, with payload mux.
// Ports:
//   req     in   REQ         request vector (polarity set by ACT)
//   data    in   REQ*DATA    per-entry payload
//   valid_c out  1           at least one active request
//   pos_c   out  REQ         winner: one-hot (BIT_MAP=ENABLE) or binary index
//   data_c  out  DATA        payload of the winner, zero when none
module rr_arbiter_selector
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned REQ     = 8,
  parameter int unsigned DATA    = 33,
  parameter bit          BIT_MAP = ENABLE,
  parameter bit          ACT     = HIGH,
  parameter bit          MSB     = DISABLE
) (
  input  logic [REQ-1:0]           req,
  input  logic [REQ-1:0][DATA-1:0] data,
  output logic                     valid_c,
  output logic [REQ-1:0]           pos_c,
  output logic [DATA-1:0]          data_c
);

  localparam int unsigned SW = idx_width(REQ);

  logic [REQ-1:0] act;
  logic [REQ-1:0] hit;
  logic [SW-1:0]  sel_idx;

  // First active entry wins; scan direction chooses LSB- or MSB-first priority.
  always_comb begin
    act     = ACT ? req : ~req;
    valid_c = 1'b0;
    hit     = '0;
    sel_idx = '0;
    data_c  = '0;
    if (MSB) begin
      for (int k = REQ - 1; k >= 0; k--) begin
        if (!valid_c && act[k]) begin
          valid_c = 1'b1;
          hit[k]  = 1'b1;
          sel_idx = SW'(k);
          data_c  = data[k];
        end
      end
    end else begin
      for (int k = 0; k < REQ; k++) begin
        if (!valid_c && act[k]) begin
          valid_c = 1'b1;
          hit[k]  = 1'b1;
          sel_idx = SW'(k);
          data_c  = data[k];
        end
      end
    end
    pos_c = BIT_MAP ? hit : REQ'(sel_idx);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Purpose: round-robin arbiter with optional burst lock and a registered output beat.
// Ports:
//   clk, reset_          clock, async active-low reset
//   req/req_data/req_last per-requester beat valid, payload, last-of-burst
//   gnt                  one-hot accept (combinational)
//   out_valid/out_data/out_last/out_idx  registered beat
//   out_ready            downstream accept
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned REQ  = 8,
  parameter int unsigned DATA = 32,
  parameter bit          LOCK = ENABLE,
  localparam int unsigned IDX = idx_width(REQ)
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic [REQ-1:0]           req,
  input  logic [REQ-1:0][DATA-1:0] req_data,
  input  logic [REQ-1:0]           req_last,
  output logic [REQ-1:0]           gnt,
  output logic                     out_valid,
  output logic [DATA-1:0]          out_data,
  output logic                     out_last,
  output logic [IDX-1:0]           out_idx,
  input  logic                     out_ready
);

  localparam int unsigned W = DATA + 1;

  state_e               state, state_nx;
  logic [IDX-1:0]       ptr, owner, win_idx;
  logic [REQ-1:0][W-1:0] beat;
  logic [REQ-1:0]       cand, mask, masked, m_pos, r_pos, win;
  logic                 m_valid, r_valid;
  logic [W-1:0]         m_data, r_data, win_data;
  logic                 adv_c, take_c, last_c, owner_ld_c;

  // Pack {last, data} per requester so the selector muxes both together.
  always_comb begin
    beat = '0;
    for (int i = 0; i < REQ; i++) beat[i] = {req_last[i], req_data[i]};
  end

  // Candidates: everyone in ARB, only the owner while a burst is locked.
  always_comb begin
    cand = req;
    if (state == ST_LOCKED) begin
      cand        = '0;
      cand[owner] = req[owner];
    end
    mask = '0;
    for (int i = 0; i < REQ; i++) mask[i] = (IDX'(i) > ptr);
    masked = cand & mask;
  end

  rr_arbiter_selector #(
    .REQ(REQ), .DATA(W), .BIT_MAP(ENABLE), .ACT(HIGH), .MSB(DISABLE)
  ) u_sel_masked (
    .req(masked), .data(beat), .valid_c(m_valid), .pos_c(m_pos), .data_c(m_data)
  );

  rr_arbiter_selector #(
    .REQ(REQ), .DATA(W), .BIT_MAP(ENABLE), .ACT(HIGH), .MSB(DISABLE)
  ) u_sel_raw (
    .req(cand), .data(beat), .valid_c(r_valid), .pos_c(r_pos), .data_c(r_data)
  );

  // Requesters above ptr take precedence; otherwise wrap to the lowest request.
  always_comb begin
    win      = m_valid ? m_pos : r_pos;
    win_data = m_valid ? m_data : r_data;
    adv_c    = !out_valid || out_ready;
    take_c   = adv_c && r_valid;
    gnt      = adv_c ? win : '0;
    last_c   = LOCK ? win_data[DATA] : 1'b1;
    win_idx  = '0;
    for (int i = 0; i < REQ; i++) if (win[i]) win_idx = win_idx | IDX'(i);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= ST_ARB;
    else         state <= state_nx;
  end

  // FSM next state.
  always_comb begin
    state_nx = state;
    case (state)
      ST_ARB:    if (take_c && LOCK && !win_data[DATA]) state_nx = ST_LOCKED;
      ST_LOCKED: if (take_c && win_data[DATA])          state_nx = ST_ARB;
      default:   state_nx = ST_ARB;
    endcase
  end

  // FSM outputs: capture the owner when a burst starts.
  always_comb begin
    owner_ld_c = 1'b0;
    if (state == ST_ARB && take_c && LOCK && !win_data[DATA]) owner_ld_c = 1'b1;
  end

  // Pointer and owner; in LOCKED the winner is the owner, so ptr lands on it.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ptr   <= IDX'(REQ - 1);
      owner <= '0;
    end else begin
      if (take_c)     ptr   <= win_idx;
      if (owner_ld_c) owner <= win_idx;
    end
  end

  // Output beat register; holds while stalled.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else if (adv_c) begin
      out_valid <= take_c;
      if (take_c) begin
        out_data <= win_data[DATA-1:0];
        out_last <= last_c;
        out_idx  <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Purpose: directed self-checking bench for rr_arbiter (locked and rotating builds).
// Ports: none.
module tb_rr_arbiter;
  import rr_arbiter_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [2:0]  i;
  } beat_t;

  logic             clk;
  logic             reset_;
  logic [7:0]       req;
  logic [7:0][31:0] req_data;
  logic [7:0]       req_last;
  logic             out_ready;

  logic [7:0]  gnt_lk, gnt_rr;
  logic        ov_lk, ov_rr, ol_lk, ol_rr;
  logic [31:0] od_lk, od_rr;
  logic [2:0]  oi_lk, oi_rr;

  int    npass  = 0;
  int    nfail  = 0;
  int    ntotal = 0;
  beat_t q[$];

  rr_arbiter #(.REQ(8), .DATA(32), .LOCK(ENABLE)) dut_lk (
    .clk(clk), .reset_(reset_), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt_lk), .out_valid(ov_lk), .out_data(od_lk), .out_last(ol_lk),
    .out_idx(oi_lk), .out_ready(out_ready)
  );

  rr_arbiter #(.REQ(8), .DATA(32), .LOCK(DISABLE)) dut_rr (
    .clk(clk), .reset_(reset_), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt_rr), .out_valid(ov_rr), .out_data(od_rr), .out_last(ol_rr),
    .out_idx(oi_rr), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check gnt, update scoreboard, then check the registered beat.
  task automatic tick(input bit rr, input logic [7:0] exp_gnt, input string tag);
    beat_t b;
    int    idx;
    #2;
    chk({tag, "_gnt"}, 64'(rr ? gnt_rr : gnt_lk), 64'(exp_gnt));
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (exp_gnt != 8'h00) begin
      idx = 0;
      for (int i = 0; i < 8; i++) if (exp_gnt[i]) idx = i;
      b.d = req_data[idx];
      b.l = rr ? 1'b1 : req_last[idx];
      b.i = 3'(idx);
      q.push_back(b);
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      chk({tag, "_valid"}, 64'(rr ? ov_rr : ov_lk), 64'(1));
      chk({tag, "_data"},  64'(rr ? od_rr : od_lk), 64'(q[0].d));
      chk({tag, "_last"},  64'(rr ? ol_rr : ol_lk), 64'(q[0].l));
      chk({tag, "_idx"},   64'(rr ? oi_rr : oi_lk), 64'(q[0].i));
    end else begin
      chk({tag, "_valid"}, 64'(rr ? ov_rr : ov_lk), 64'(0));
    end
  endtask

  task automatic do_reset();
    reset_    = 1'b0;
    req       = 8'h00;
    req_last  = 8'h00;
    out_ready = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  initial begin
    req_data = '0;
    do_reset();

    // Idle after reset.
    chk("rst_valid", 64'(ov_lk), 64'(0));
    chk("rst_data",  64'(od_lk), 64'(0));
    chk("rst_last",  64'(ol_lk), 64'(0));
    chk("rst_idx",   64'(oi_lk), 64'(0));
    chk("rst_gnt_rr", 64'(gnt_rr), 64'(0));
    repeat (5) tick(1'b0, 8'h00, "idle");
    chk("idle_idx", 64'(oi_lk), 64'(0));

    // Rotating build, everyone requesting.
    do_reset();
    for (int i = 0; i < 8; i++) req_data[i] = 32'h1000 + 32'(i);
    req = 8'hFF;
    for (int n = 0; n < 10; n++) tick(1'b1, 8'(8'h01 << (n % 8)), "rot");
    req = 8'h00;
    tick(1'b1, 8'h00, "rot_drain");

    // Locked burst from requester 4 while requester 0 waits.
    do_reset();
    req         = 8'h11;
    req_last    = 8'h01;
    req_data[0] = 32'h0000_00A0;
    req_data[4] = 32'h0000_00B1;
    tick(1'b0, 8'h01, "lk_r0");
    tick(1'b0, 8'h10, "lk_b1");
    req_data[4] = 32'h0000_00B2;
    tick(1'b0, 8'h10, "lk_b2");
    req_data[4] = 32'h0000_00B3;
    req_last[4] = 1'b1;
    tick(1'b0, 8'h10, "lk_b3");
    tick(1'b0, 8'h01, "lk_r0b");
    req = 8'h00;
    tick(1'b0, 8'h00, "lk_drain");

    // Backpressure: output holds, no grants; ready releases grant same cycle.
    do_reset();
    req         = 8'h02;
    req_last    = 8'h02;
    req_data[1] = 32'h0000_00C1;
    tick(1'b0, 8'h02, "bp_first");
    out_ready = 1'b0;
    repeat (4) tick(1'b0, 8'h00, "bp_stall");
    out_ready   = 1'b1;
    req_data[1] = 32'h0000_00C2;
    tick(1'b0, 8'h02, "bp_go");
    req = 8'h00;
    tick(1'b0, 8'h00, "bp_drain");

    // Owner drops req mid-burst; channel stays locked.
    do_reset();
    req         = 8'h28;
    req_last    = 8'h20;
    req_data[3] = 32'h0000_00D1;
    req_data[5] = 32'h0000_00E0;
    tick(1'b0, 8'h08, "drop_b1");
    req = 8'h20;
    repeat (3) tick(1'b0, 8'h00, "drop_wait");
    req         = 8'h28;
    req_data[3] = 32'h0000_00D2;
    tick(1'b0, 8'h08, "drop_b2");
    req_data[3] = 32'h0000_00D3;
    req_last[3] = 1'b1;
    tick(1'b0, 8'h08, "drop_b3");
    tick(1'b0, 8'h20, "drop_r5");
    req = 8'h00;
    tick(1'b0, 8'h00, "drop_drain");

    // Reset mid-burst: asynchronous clear, lock and pointer forgotten.
    do_reset();
    req         = 8'h04;
    req_data[2] = 32'h0000_00F1;
    tick(1'b0, 8'h04, "mid_b1");
    reset_ = 1'b0;
    #1;
    chk("mid_async_valid", 64'(ov_lk), 64'(0));
    chk("mid_async_idx",   64'(oi_lk), 64'(0));
    q.delete();
    req = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset_      = 1'b1;
    req         = 8'h41;
    req_last    = 8'h41;
    req_data[0] = 32'h0000_00AA;
    req_data[6] = 32'h0000_0066;
    tick(1'b0, 8'h01, "mid_after");
    req = 8'h00;
    tick(1'b0, 8'h00, "mid_drain");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
